// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with a valid-qualified registered copy.
// Optional macro FULL_ADDER_OVF_EN adds signed-overflow outputs ovf (comb) and ovf_q (registered).
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  output logic [WIDTH-1:0] s,
  output logic             c,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s_q,
  output logic             c_q,
  output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  // Ripple carry chain: w_k[i] is the carry into bit i.
  logic [WIDTH:0] w_k;

  assign w_k[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s[i]     = a[i] ^ b[i] ^ w_k[i];
    assign w_k[i+1] = (a[i] & b[i]) | (w_k[i] & (a[i] ^ b[i]));
  end

  assign c = w_k[WIDTH];

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign ovf = w_k[WIDTH-1] ^ w_k[WIDTH];
  logic r_ovf_q;
  assign ovf_q = r_ovf_q;
`endif

  logic [WIDTH-1:0] r_s_q;
  logic             r_c_q;
  logic             r_out_valid;

  assign s_q       = r_s_q;
  assign c_q       = r_c_q;
  assign out_valid = r_out_valid;

  // Capture stage: reset wins over in_valid; result holds while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s_q       <= '0;
      r_c_q       <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
      r_ovf_q     <= 1'b0;
`endif
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_s_q   <= s;
        r_c_q   <= c;
`ifdef FULL_ADDER_OVF_EN
        r_ovf_q <= ovf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: WIDTH=1 and WIDTH=8 instances checked against an arithmetic model.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, iv1 = 1'b0;
  logic       s1, c1, sq1, cq1, ov1;
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic       cin8 = 1'b0, iv8 = 1'b0;
  logic [7:0] s8, sq8;
  logic       c8, cq8, ov8;
`ifdef FULL_ADDER_OVF_EN
  logic       ovf1, ovfq1, ovf8, ovfq8;
  logic       e_ovfq8;
`endif

  logic       e_sq1, e_cq1, e_ov1;
  logic [7:0] e_sq8;
  logic       e_cq8, e_ov8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_dut1 (
    .s(s1), .c(c1), .a(a1), .b(b1), .cin(cin1),
    .clk(clk), .rst_n(rst_n), .in_valid(iv1),
    .s_q(sq1), .c_q(cq1), .out_valid(ov1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf1), .ovf_q(ovfq1)
`endif
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .s(s8), .c(c8), .a(a8), .b(b8), .cin(cin8),
    .clk(clk), .rst_n(rst_n), .in_valid(iv8),
    .s_q(sq8), .c_q(cq8), .out_valid(ov8)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf8), .ovf_q(ovfq8)
`endif
  );

  // Unsigned sum of an 8-bit addition as a plain integer.
  function automatic int usum8(input logic [7:0] x, input logic [7:0] y, input logic ci);
    return int'(x) + int'(y) + int'(ci);
  endfunction

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow: the true signed result falls outside the 8-bit range.
  function automatic logic ovf_ref8(input logic [7:0] x, input logic [7:0] y, input logic ci);
    int sx, sy, r;
    sx = (int'(x) >= 128) ? int'(x) - 256 : int'(x);
    sy = (int'(y) >= 128) ? int'(y) - 256 : int'(y);
    r  = sx + sy + int'(ci);
    return (r > 127) || (r < -128);
  endfunction
`endif

  // Drive one cycle of stimulus on both instances and advance the registered model.
  task automatic cycle(input logic rst, input logic v1, input logic xa1, input logic xb1,
                       input logic xc1, input logic v8, input logic [7:0] xa8,
                       input logic [7:0] xb8, input logic xc8);
    int sum;
    @(negedge clk);
    rst_n = rst; iv1 = v1; a1 = xa1; b1 = xb1; cin1 = xc1;
    iv8 = v8; a8 = xa8; b8 = xb8; cin8 = xc8;
    @(posedge clk);
    if (!rst) begin
      e_sq1 = 1'b0; e_cq1 = 1'b0; e_ov1 = 1'b0;
      e_sq8 = 8'h00; e_cq8 = 1'b0; e_ov8 = 1'b0;
`ifdef FULL_ADDER_OVF_EN
      e_ovfq8 = 1'b0;
`endif
    end else begin
      e_ov1 = v1;
      if (v1) begin
        sum   = int'(xa1) + int'(xb1) + int'(xc1);
        e_sq1 = (sum % 2) == 1;
        e_cq1 = sum >= 2;
      end
      e_ov8 = v8;
      if (v8) begin
        sum   = usum8(xa8, xb8, xc8);
        e_sq8 = 8'(sum % 256);
        e_cq8 = sum >= 256;
`ifdef FULL_ADDER_OVF_EN
        e_ovfq8 = ovf_ref8(xa8, xb8, xc8);
`endif
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
      n_vec++;
      if ({sq1, cq1, ov1} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_w1 edge%0d got s_q,c_q,out_valid=%b%b%b want 000", i, sq1, cq1, ov1);
      end
      n_vec++;
      if ({sq8, cq8, ov8} !== 10'h000) begin
        n_err++;
        $display("FAIL reset_w8 edge%0d got s_q=%h c_q=%b out_valid=%b want 00 0 0", i, sq8, cq8, ov8);
      end
    end
  endtask

  task automatic test_comb_steps();
    logic [2:0] steps [4];
    logic [1:0] want  [4];
    steps[0] = 3'b000; want[0] = 2'b00;
    steps[1] = 3'b100; want[1] = 2'b01;
    steps[2] = 3'b110; want[2] = 2'b10;
    steps[3] = 3'b111; want[3] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      {a1, b1, cin1} = steps[i];
      #1;
      n_vec++;
      if ({c1, s1} !== want[i]) begin
        n_err++;
        $display("FAIL comb_step%0d got c,s=%b%b want %b", i, c1, s1, want[i]);
      end
      #9;
    end
  endtask

  task automatic test_exhaustive();
    int exp_sum;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, cin1} = 3'(i);
      exp_sum = ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1);
      #1;
      n_vec++;
      if ({c1, s1} !== 2'(exp_sum)) begin
        n_err++;
        $display("FAIL exhaustive abc=%b got c,s=%b%b want %0d", 3'(i), c1, s1, exp_sum);
      end
    end
  endtask

  task automatic test_width8_boundaries();
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic       tc [3];
    int sum;
    ta[0] = 8'hFF; tb[0] = 8'h00; tc[0] = 1'b1;
    ta[1] = 8'h7F; tb[1] = 8'h01; tc[1] = 1'b0;
    ta[2] = 8'hFF; tb[2] = 8'hFF; tc[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a8 = ta[i]; b8 = tb[i]; cin8 = tc[i];
      #1;
      sum = usum8(ta[i], tb[i], tc[i]);
      n_vec++;
      if ({c8, s8} !== 9'(sum)) begin
        n_err++;
        $display("FAIL w8_bound%0d got c=%b s=%h want %h", i, c8, s8, 9'(sum));
      end
    end
    // Spot values quoted directly rather than derived.
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
    #1;
    n_vec++;
    if ({c8, s8} !== 9'h080) begin
      n_err++;
      $display("FAIL w8_7f_plus_1 got c=%b s=%h want c=0 s=80", c8, s8);
    end
`ifdef FULL_ADDER_OVF_EN
    n_vec++;
    if (ovf8 !== 1'b1) begin
      n_err++;
      $display("FAIL w8_ovf got %b want 1", ovf8);
    end
`endif
  endtask

  task automatic check_regs(input string name);
    n_vec++;
    if ({sq1, cq1, ov1} !== {e_sq1, e_cq1, e_ov1}) begin
      n_err++;
      $display("FAIL %s_w1 got s_q,c_q,out_valid=%b%b%b want %b%b%b",
               name, sq1, cq1, ov1, e_sq1, e_cq1, e_ov1);
    end
    n_vec++;
    if ({sq8, cq8, ov8} !== {e_sq8, e_cq8, e_ov8}) begin
      n_err++;
      $display("FAIL %s_w8 got s_q=%h c_q=%b out_valid=%b want %h %b %b",
               name, sq8, cq8, ov8, e_sq8, e_cq8, e_ov8);
    end
`ifdef FULL_ADDER_OVF_EN
    n_vec++;
    if (ovfq8 !== e_ovfq8) begin
      n_err++;
      $display("FAIL %s_ovf_q got %b want %b", name, ovfq8, e_ovfq8);
    end
`endif
  endtask

  task automatic test_registered();
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    n_vec++;
    if ({cq1, sq1, ov1} !== 3'b111) begin
      n_err++;
      $display("FAIL reg_capture got c_q,s_q,out_valid=%b%b%b want 111", cq1, sq1, ov1);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    n_vec++;
    if ({cq1, sq1, ov1} !== 3'b110) begin
      n_err++;
      $display("FAIL reg_hold got c_q,s_q,out_valid=%b%b%b want 110", cq1, sq1, ov1);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
            1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      check_regs("stream");
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    n_vec++;
    if ({sq1, cq1, ov1, sq8, cq8, ov8} !== 13'h0) begin
      n_err++;
      $display("FAIL mid_reset got w1=%b%b%b w8 s_q=%h c_q=%b v=%b want all 0",
               sq1, cq1, ov1, sq8, cq8, ov8);
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 8'h34, 1'b1);
    n_vec++;
    if ({cq1, sq1, ov1, cq8, sq8, ov8} !== {3'b011, 1'b0, 8'h47, 1'b1}) begin
      n_err++;
      $display("FAIL post_release got w1 c,s,v=%b%b%b w8 c=%b s=%h v=%b want 011 0 47 1",
               cq1, sq1, ov1, cq8, sq8, ov8);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [4];
    ops[0] = 3'b000; ops[1] = 3'b100; ops[2] = 3'b110; ops[3] = 3'b111;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, ops[i][2], ops[i][1], ops[i][0], 1'b0, 8'h00, 8'h00, 1'b0);
      n_vec++;
      if ({ov1, cq1, sq1} !== {1'b1, 2'(i)}) begin
        n_err++;
        $display("FAIL b2b%0d got out_valid=%b c_q,s_q=%b%b want 1 %b", i, ov1, cq1, sq1, 2'(i));
      end
    end
  endtask

  task automatic test_random();
    logic       rst, v1, v8, xc1, xc8, xa1, xb1;
    logic [7:0] xa8, xb8;
    int sum;
    for (int n = 0; n < 200; n++) begin
      rst = ($urandom_range(0, 19) != 0);
      v1 = 1'($urandom); v8 = 1'($urandom);
      xa1 = 1'($urandom); xb1 = 1'($urandom); xc1 = 1'($urandom);
      xa8 = 8'($urandom); xb8 = 8'($urandom); xc8 = 1'($urandom);
      if (n % 16 == 0) begin xa8 = 8'hFF; xb8 = 8'($urandom_range(0, 1)); end
      cycle(rst, v1, xa1, xb1, xc1, v8, xa8, xb8, xc8);
      check_regs("random");
      sum = usum8(xa8, xb8, xc8);
      n_vec++;
      if ({c8, s8} !== 9'(sum)) begin
        n_err++;
        $display("FAIL random_comb a=%h b=%h cin=%b got c=%b s=%h want %h",
                 xa8, xb8, xc8, c8, s8, 9'(sum));
      end
`ifdef FULL_ADDER_OVF_EN
      n_vec++;
      if (ovf8 !== ovf_ref8(xa8, xb8, xc8)) begin
        n_err++;
        $display("FAIL random_ovf a=%h b=%h cin=%b got %b", xa8, xb8, xc8, ovf8);
      end
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_comb_steps();
    test_exhaustive();
    test_width8_boundaries();
    test_registered();
    test_reset_midstream();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
